debugger_multichannel: RTL and testbench
========================================

// Module: debugger_multichannel
// PURPOSE
//  UART debug probe generalising the single-word debugger to NUM_CHANNELS probe words of DATA_WIDTH bits.
//  An 8N1 command byte on debug_uart_rx_in selects a channel and a mode: one-shot snapshot or periodic streaming.
//  The block answers with a framed 8N1 dump on tx_out. It sits beside the display pipeline, fed by internal status buses.
// PARAMETERS
//  DIVIDER_TICKS  191      clk_in cycles per UART bit (RX and TX); >=4
//  DATA_WIDTH     24       bits per probe channel; 1..64
//  NUM_CHANNELS   4        probe channels; 1..16
//  STREAM_PERIOD  1048576  clk_in cycles between streaming-frame triggers; >=1
// PORTS
//  clk_in            in   1                        system clock
//  reset             in   1                        synchronous, active-high
//  data_in           in   NUM_CHANNELS*DATA_WIDTH  channel k = data_in[k*DATA_WIDTH +: DATA_WIDTH]
//  debug_uart_rx_in  in   1                        UART RX, async, idle high
//  tx_out            out  1                        UART TX, idle high
//  debug_start       out  1                        1-cycle pulse: channel word captured, frame begins
//  busy              out  1                        high while a frame is on tx_out
//  cmd_error         out  1                        1-cycle pulse: bad opcode/channel or RX framing error
// BEHAVIOUR
//  Reset: tx_out=1, debug_start=0, busy=0, cmd_error=0. Stream mode off, pending flag clear, counters 0.
//  A reset mid-frame forces tx_out=1 on the next edge; any partial RX byte is discarded.
//  RX: 2-flop synchroniser, then start-bit detect on a 1->0 transition.
//   - After DIVIDER_TICKS/2 cycles the line is re-checked; if high, it was a glitch -> back to idle, no error.
//   - Data bits (LSB first) are then sampled every DIVIDER_TICKS cycles, followed by the stop bit.
//   - Stop bit 0 -> byte dropped, cmd_error pulses 1 cycle.
//  Command byte [7:4]=opcode, [3:0]=chan, decoded on the cycle after the stop-bit sample:
//   0x1 snapshot: set the pending flag with chan (a later snapshot overwrites a pending one).
//   0x2 stream start: stream_chan=chan, stream on, period counter reset to 0.
//   0x3 stop: stream off; a frame already in flight completes normally.
//   Any other opcode, or chan>=NUM_CHANNELS -> cmd_error pulse, state unchanged.
//  Triggers:
//   - Period counter counts 0..STREAM_PERIOD-1 while streaming and sets stream_due on wrap.
//   - When the TX FSM is idle, pending beats stream_due; a loser stays set. Each flag clears when served.
//   - Triggers never stack: at most one pending snapshot and one stream_due flag.
//  TX FSM: IDLE -> LOAD -> START -> DATA -> STOP -> (NEXT byte ? START : IDLE).
//   LOAD (1 cycle): capture the selected channel word and assert debug_start. busy rises and tx_out=0 from the next cycle.
//   Frame = header byte {4'hA, chan}, then NB=ceil(DATA_WIDTH/8) bytes, MSB byte first.
//   Word is zero-extended to NB*8 bits; each byte is 8N1, LSB first, DIVIDER_TICKS cycles per bit.
//   Bytes are back-to-back with no idle gap. busy lasts exactly (1+NB)*10*DIVIDER_TICKS cycles; it falls when the last stop bit ends.
//   data_in changes after LOAD do not affect the frame in flight.
//  Full-duplex: RX continues and commands decode while TX is busy.
//  A simultaneous cmd_error source and a valid decode cannot occur; only one byte completes per cycle.
// TESTING
//  (bench params: DIVIDER_TICKS=16, DATA_WIDTH=24, NUM_CHANNELS=4, STREAM_PERIOD=2000; ch2=24'hF0AA0D, ch1=24'h123456)
//  Send 0x12 -> one debug_start; tx bytes A2 F0 AA 0D; busy high exactly 640 cycles; tx_out idle high after.
//  Send 0x15 and 0x72 -> a cmd_error pulse for each; no debug_start; tx_out stays 1.
//  Send 0x21 -> frames A1 12 34 56 start every 2000 cycles. Send 0x30 mid-frame -> frame completes, no further frames.
//  Stop bit driven 0 -> cmd_error pulse, no TX. RX low for 3 cycles only -> no byte, no error.
//  Send 0x12 then 0x10 during the frame -> A2 frame, then an A0 frame immediately after. Reset mid-frame -> tx_out=1, busy=0 next cycle.
//  Rebuild with DATA_WIDTH=12, ch0=12'hABC, send 0x10 -> bytes A0 0A BC; busy = 480 cycles.

Source files
------------

// File: rtl/debugger_multichannel.sv
// UART debug probe: an 8N1 command byte selects one of NUM_CHANNELS probe words
// for a one-shot snapshot or periodic streaming; the word is returned as a framed 8N1 dump.
module debugger_multichannel #(
  parameter int unsigned DIVIDER_TICKS = 191,
  parameter int unsigned DATA_WIDTH    = 24,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned STREAM_PERIOD = 1048576
) (
  input  logic                               clk_in,
  input  logic                               reset,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                               debug_uart_rx_in,
  output logic                               tx_out,
  output logic                               debug_start,
  output logic                               busy,
  output logic                               cmd_error
);

  localparam int unsigned NB      = (DATA_WIDTH + 7) / 8;
  localparam int unsigned WORD_W  = NB * 8;
  localparam int unsigned FRAME_W = WORD_W + 8;
  localparam int unsigned CNT_W   = $clog2(DIVIDER_TICKS);
  localparam int unsigned PER_W   = (STREAM_PERIOD > 1) ? $clog2(STREAM_PERIOD) : 1;
  localparam int unsigned BIDX_W  = $clog2(NB + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DIVIDER_TICKS - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(DIVIDER_TICKS / 2 - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(STREAM_PERIOD - 1);
  localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(NB);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_state_t;

  rx_state_t          rx_state_q, rx_state_d;
  tx_state_t          tx_state_q, tx_state_d;
  logic               rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2:0]         rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [7:0]         rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic               rx_done_q, rx_done_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [BIDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [3:0]         sel_chan_q, sel_chan_d, pend_chan_q, pend_chan_d, stream_chan_q, stream_chan_d;
  logic               pend_q, pend_d, stream_on_q, stream_on_d, due_q, due_d;
  logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
  logic               tx_q, tx_d, ds_q, ds_d, busy_q, busy_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] sel_word;
  logic [FRAME_W-1:0]    load_frame;
  logic                  chan_ok;

  // Channel word mux for the LOAD cycle
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (sel_chan_q == 4'(k)) sel_word = data_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
    load_frame = {4'hA, sel_chan_q, WORD_W'(sel_word)};
    chan_ok    = 32'(rx_sh_q[3:0]) < NUM_CHANNELS;
  end

  // Next-state and next-output logic for RX, triggers and TX
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q + CNT_W'(1);
    rx_bit_d      = rx_bit_q;
    rx_sh_d       = rx_sh_q;
    rx_done_d     = 1'b0;
    tx_state_d    = tx_state_q;
    tx_cnt_d      = tx_cnt_q + CNT_W'(1);
    tx_bit_d      = tx_bit_q;
    tx_sh_d       = tx_sh_q;
    frame_d       = frame_q;
    byte_idx_d    = byte_idx_q;
    sel_chan_d    = sel_chan_q;
    pend_d        = pend_q;
    pend_chan_d   = pend_chan_q;
    stream_on_d   = stream_on_q;
    stream_chan_d = stream_chan_q;
    due_d         = due_q;
    per_cnt_d     = per_cnt_q;
    tx_d          = tx_q;
    ds_d          = 1'b0;
    busy_d        = busy_q;
    err_d         = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_state_d = RX_IDLE;
        if (rx_s2_q) rx_done_d = 1'b1;
        else         err_d     = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase

    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (pend_q) begin
          tx_state_d = TX_LOAD;
          sel_chan_d = pend_chan_q;
          pend_d     = 1'b0;
          ds_d       = 1'b1;
        end else if (due_q) begin
          tx_state_d = TX_LOAD;
          sel_chan_d = stream_chan_q;
          due_d      = 1'b0;
          ds_d       = 1'b1;
        end
      end
      TX_LOAD: begin
        tx_cnt_d   = '0;
        tx_sh_d    = load_frame[FRAME_W-1 -: 8];
        frame_d    = {load_frame[FRAME_W-9:0], 8'h00};
        byte_idx_d = '0;
        busy_d     = 1'b1;
        tx_d       = 1'b0;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_sh_q[0];
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_d       = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d  = tx_sh_q >> 1;
          tx_d     = tx_sh_q[1];
        end
      end
      TX_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (byte_idx_q == BYTE_LAST) begin
          busy_d     = 1'b0;
          tx_state_d = TX_IDLE;
        end else begin
          byte_idx_d = byte_idx_q + BIDX_W'(1);
          tx_sh_d    = frame_q[FRAME_W-1 -: 8];
          frame_d    = {frame_q[FRAME_W-9:0], 8'h00};
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Period counter; a wrap re-arms stream_due even if it was just served
    if (stream_on_q) begin
      if (per_cnt_q == PER_LAST) begin
        per_cnt_d = '0;
        due_d     = 1'b1;
      end else begin
        per_cnt_d = per_cnt_q + PER_W'(1);
      end
    end

    // Command decode runs last so a fresh snapshot survives a same-cycle serve
    if (rx_done_q) begin
      if (!chan_ok) begin
        err_d = 1'b1;
      end else begin
        case (rx_sh_q[7:4])
          4'h1: begin
            pend_d      = 1'b1;
            pend_chan_d = rx_sh_q[3:0];
          end
          4'h2: begin
            stream_on_d   = 1'b1;
            stream_chan_d = rx_sh_q[3:0];
            per_cnt_d     = '0;
          end
          4'h3:    stream_on_d = 1'b0;
          default: err_d       = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RX_IDLE;
      tx_state_q    <= TX_IDLE;
      rx_cnt_q      <= '0;
      tx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      tx_bit_q      <= '0;
      rx_sh_q       <= '0;
      tx_sh_q       <= '0;
      rx_done_q     <= 1'b0;
      frame_q       <= '0;
      byte_idx_q    <= '0;
      sel_chan_q    <= '0;
      pend_q        <= 1'b0;
      pend_chan_q   <= '0;
      stream_on_q   <= 1'b0;
      stream_chan_q <= '0;
      due_q         <= 1'b0;
      per_cnt_q     <= '0;
      tx_q          <= 1'b1;
      ds_q          <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rx_s1_q       <= debug_uart_rx_in;
      rx_s2_q       <= rx_s1_q;
      rx_prev_q     <= rx_s2_q;
      rx_state_q    <= rx_state_d;
      tx_state_q    <= tx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      tx_bit_q      <= tx_bit_d;
      rx_sh_q       <= rx_sh_d;
      tx_sh_q       <= tx_sh_d;
      rx_done_q     <= rx_done_d;
      frame_q       <= frame_d;
      byte_idx_q    <= byte_idx_d;
      sel_chan_q    <= sel_chan_d;
      pend_q        <= pend_d;
      pend_chan_q   <= pend_chan_d;
      stream_on_q   <= stream_on_d;
      stream_chan_q <= stream_chan_d;
      due_q         <= due_d;
      per_cnt_q     <= per_cnt_d;
      tx_q          <= tx_d;
      ds_q          <= ds_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign tx_out      = tx_q;
  assign debug_start = ds_q;
  assign busy        = busy_q;
  assign cmd_error   = err_q;

endmodule

// File: tb/tb_debugger_multichannel.sv
// Directed bench for debugger_multichannel: a 24-bit and a 12-bit instance share the RX line,
// a UART monitor decodes whichever instance is selected.
module tb_debugger_multichannel;

  localparam int unsigned DIV = 16;

  logic         tb_clk_baudrate;
  logic         reset;
  logic         rx;
  logic [95:0]  data24;
  logic [47:0]  data12;
  logic         tx24, ds24, busy24, err24;
  logic         tx12, ds12, busy12, err12;
  logic         use12;
  logic         mon_tx, mon_ds, mon_busy, mon_err;

  int           compared = 0;
  int           mismatched = 0;
  int           cycle = 0;
  int           ds_cnt = 0;
  int           ce_cnt = 0;
  int           tx_low = 0;
  int           stop_bad = 0;
  int           busy_run = 0;
  int           busy_last = 0;
  int           ds_time[$];
  logic [7:0]   rx_bytes[$];
  logic [7:0]   mon_b;

  debugger_multichannel #(
    .DIVIDER_TICKS(DIV), .DATA_WIDTH(24), .NUM_CHANNELS(4), .STREAM_PERIOD(2000)
  ) dut (
    .clk_in(tb_clk_baudrate), .reset(reset), .data_in(data24), .debug_uart_rx_in(rx),
    .tx_out(tx24), .debug_start(ds24), .busy(busy24), .cmd_error(err24)
  );

  debugger_multichannel #(
    .DIVIDER_TICKS(DIV), .DATA_WIDTH(12), .NUM_CHANNELS(4), .STREAM_PERIOD(2000)
  ) dut12 (
    .clk_in(tb_clk_baudrate), .reset(reset), .data_in(data12), .debug_uart_rx_in(rx),
    .tx_out(tx12), .debug_start(ds12), .busy(busy12), .cmd_error(err12)
  );

  assign mon_tx   = use12 ? tx12   : tx24;
  assign mon_ds   = use12 ? ds12   : ds24;
  assign mon_busy = use12 ? busy12 : busy24;
  assign mon_err  = use12 ? err12  : err24;

  initial begin
    tb_clk_baudrate = 1'b0;
    forever #5 tb_clk_baudrate = ~tb_clk_baudrate;
  end

  // Event counters and busy-run length of the selected instance
  always @(negedge tb_clk_baudrate) begin
    cycle <= cycle + 1;
    if (mon_ds === 1'b1) begin
      ds_cnt <= ds_cnt + 1;
      ds_time.push_back(cycle);
    end
    if (mon_err === 1'b1) ce_cnt <= ce_cnt + 1;
    if (mon_tx !== 1'b1) tx_low <= tx_low + 1;
    if (mon_busy === 1'b1) busy_run <= busy_run + 1;
    else if (busy_run != 0) begin
      busy_last <= busy_run;
      busy_run  <= 0;
    end
  end

  // 8N1 receiver on the selected tx line, sampling mid-bit
  always begin
    @(negedge tb_clk_baudrate);
    if (mon_tx === 1'b0 && reset === 1'b0) begin
      repeat (DIV/2) @(negedge tb_clk_baudrate);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge tb_clk_baudrate);
        mon_b[i] = mon_tx;
      end
      repeat (DIV) @(negedge tb_clk_baudrate);
      if (mon_tx !== 1'b1) stop_bad = stop_bad + 1;
      rx_bytes.push_back(mon_b);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] byte_at(input int idx);
    if (idx < rx_bytes.size()) return 64'(rx_bytes[idx]);
    return 64'hDEAD;
  endfunction

  task automatic check_frame4(input string tag, input int base,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    check($sformatf("%s_b0", tag), byte_at(base),     64'(b0));
    check($sformatf("%s_b1", tag), byte_at(base + 1), 64'(b1));
    check($sformatf("%s_b2", tag), byte_at(base + 2), 64'(b2));
    check($sformatf("%s_b3", tag), byte_at(base + 3), 64'(b3));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge tb_clk_baudrate);
    rx = 1'b0;
    repeat (DIV) @(negedge tb_clk_baudrate);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge tb_clk_baudrate);
    end
    rx = stop_bit;
    repeat (DIV) @(negedge tb_clk_baudrate);
    rx = 1'b1;
    repeat (DIV) @(negedge tb_clk_baudrate);
  endtask

  task automatic wait_ds(input int target, input int limit, input string tag);
    int n;
    n = 0;
    while (ds_cnt < target && n < limit) begin
      @(negedge tb_clk_baudrate);
      n++;
    end
    check(tag, 64'(ds_cnt >= target), 64'd1);
  endtask

  initial begin
    int ds0, ce0, q0, t0, low0;
    reset  = 1'b1;
    rx     = 1'b1;
    use12  = 1'b0;
    data24 = {24'h000000, 24'hF0AA0D, 24'h123456, 24'h5A5A01};
    data12 = {12'h789, 12'h456, 12'h123, 12'hABC};
    repeat (3) @(negedge tb_clk_baudrate);
    check("rst_tx", 64'(tx24), 64'd1);
    check("rst_busy", 64'(busy24), 64'd0);
    check("rst_ds", 64'(ds24), 64'd0);
    check("rst_err", 64'(err24), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge tb_clk_baudrate);

    // Snapshot of channel 2
    ds0 = ds_cnt; ce0 = ce_cnt; q0 = rx_bytes.size();
    send_byte(8'h12, 1'b1);
    repeat (900) @(negedge tb_clk_baudrate);
    check("snap_ds", 64'(ds_cnt - ds0), 64'd1);
    check("snap_nbytes", 64'(rx_bytes.size() - q0), 64'd4);
    check_frame4("snap", q0, 8'hA2, 8'hF0, 8'hAA, 8'h0D);
    check("snap_busy_len", 64'(busy_last), 64'd640);
    check("snap_tx_idle", 64'(tx24), 64'd1);
    check("snap_no_err", 64'(ce_cnt - ce0), 64'd0);
    check("snap_stop_bits", 64'(stop_bad), 64'd0);

    // Bad channel and bad opcode
    ds0 = ds_cnt; ce0 = ce_cnt; low0 = tx_low;
    send_byte(8'h15, 1'b1);
    repeat (50) @(negedge tb_clk_baudrate);
    check("badchan_err", 64'(ce_cnt - ce0), 64'd1);
    send_byte(8'h72, 1'b1);
    repeat (50) @(negedge tb_clk_baudrate);
    check("badop_err", 64'(ce_cnt - ce0), 64'd2);
    check("bad_no_ds", 64'(ds_cnt - ds0), 64'd0);
    check("bad_tx_high", 64'(tx_low - low0), 64'd0);

    // Streaming channel 1, stopped during the third frame
    ds0 = ds_cnt; q0 = rx_bytes.size(); t0 = ds_time.size();
    send_byte(8'h21, 1'b1);
    wait_ds(ds0 + 3, 7000, "stream_3frames");
    check("stream_period1", 64'(ds_time[t0+1] - ds_time[t0]), 64'd2000);
    check("stream_period2", 64'(ds_time[t0+2] - ds_time[t0+1]), 64'd2000);
    repeat (200) @(negedge tb_clk_baudrate);
    send_byte(8'h30, 1'b1);
    repeat (2600) @(negedge tb_clk_baudrate);
    check("stream_stop_ds", 64'(ds_cnt - ds0), 64'd3);
    check("stream_nbytes", 64'(rx_bytes.size() - q0), 64'd12);
    check_frame4("stream_f1", q0, 8'hA1, 8'h12, 8'h34, 8'h56);
    check_frame4("stream_f3", q0 + 8, 8'hA1, 8'h12, 8'h34, 8'h56);
    check("stream_busy_len", 64'(busy_last), 64'd640);

    // RX stop-bit error, then a short glitch
    ds0 = ds_cnt; ce0 = ce_cnt; q0 = rx_bytes.size();
    send_byte(8'h12, 1'b0);
    repeat (300) @(negedge tb_clk_baudrate);
    check("stopbit_err", 64'(ce_cnt - ce0), 64'd1);
    check("stopbit_no_ds", 64'(ds_cnt - ds0), 64'd0);
    rx = 1'b0;
    repeat (3) @(negedge tb_clk_baudrate);
    rx = 1'b1;
    repeat (300) @(negedge tb_clk_baudrate);
    check("glitch_no_err", 64'(ce_cnt - ce0), 64'd1);
    check("glitch_no_ds", 64'(ds_cnt - ds0), 64'd0);
    check("glitch_no_tx", 64'(rx_bytes.size() - q0), 64'd0);

    // Snapshot queued behind a frame; data change after LOAD is ignored
    ds0 = ds_cnt; q0 = rx_bytes.size(); t0 = ds_time.size();
    send_byte(8'h12, 1'b1);
    wait_ds(ds0 + 1, 400, "queue_first");
    data24[71:48] = 24'h111111;
    send_byte(8'h10, 1'b1);
    wait_ds(ds0 + 2, 1000, "queue_second");
    repeat (800) @(negedge tb_clk_baudrate);
    data24[71:48] = 24'hF0AA0D;
    check("queue_ds", 64'(ds_cnt - ds0), 64'd2);
    check("queue_gap", 64'(ds_time[t0+1] - ds_time[t0]), 64'd642);
    check_frame4("queue_f1", q0, 8'hA2, 8'hF0, 8'hAA, 8'h0D);
    check_frame4("queue_f2", q0 + 4, 8'hA0, 8'h5A, 8'h5A, 8'h01);

    // Reset in the middle of a frame
    ds0 = ds_cnt;
    send_byte(8'h12, 1'b1);
    wait_ds(ds0 + 1, 400, "rstmid_start");
    repeat (100) @(negedge tb_clk_baudrate);
    check("rstmid_busy_before", 64'(busy24), 64'd1);
    reset = 1'b1;
    @(negedge tb_clk_baudrate);
    check("rstmid_tx", 64'(tx24), 64'd1);
    check("rstmid_busy", 64'(busy24), 64'd0);
    reset = 1'b0;
    repeat (1000) @(negedge tb_clk_baudrate);
    check("rstmid_no_more", 64'(ds_cnt - ds0), 64'd1);

    // 12-bit instance: two data bytes
    use12 = 1'b1;
    repeat (5) @(negedge tb_clk_baudrate);
    ds0 = ds_cnt; q0 = rx_bytes.size();
    send_byte(8'h10, 1'b1);
    repeat (700) @(negedge tb_clk_baudrate);
    check("w12_ds", 64'(ds_cnt - ds0), 64'd1);
    check("w12_nbytes", 64'(rx_bytes.size() - q0), 64'd3);
    check("w12_b0", byte_at(q0), 64'hA0);
    check("w12_b1", byte_at(q0 + 1), 64'h0A);
    check("w12_b2", byte_at(q0 + 2), 64'hBC);
    check("w12_busy_len", 64'(busy_last), 64'd480);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
